// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI initiator.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int RD_W    = 8;
  localparam int RD_WAIT = 2;
  localparam int CNT_W   = 4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT_OUT,
    TURNAROUND,
    SHIFT_IN,
    FINISH
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI initiator: outbound shift register, inbound capture
// register, returned-byte holding register and the shared down-counter.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift_out,
  input  logic               shift_in,
  input  logic               rd_load,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_init,
  input  logic               cnt_dec,
  input  logic               miso,
  output logic               mosi,
  output logic               cnt_zero,
  output logic [RD_W-1:0]    rd_data
);

  logic [FRAME_W-1:0] tx_q;
  logic [RD_W-1:0]    rx_q;
  logic [RD_W-1:0]    rx_next;
  logic [CNT_W-1:0]   cnt_q;

  assign rx_next  = {rx_q[RD_W-2:0], miso};
  assign cnt_zero = (cnt_q == '0);
  // Zero-fill on shift: after the last bit leaves, mosi rests at 0.
  assign mosi     = tx_q[FRAME_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= '0;
      rx_q    <= '0;
      rd_data <= '0;
      cnt_q   <= '0;
    end else begin
      if (load)
        tx_q <= frame;
      else if (shift_out)
        tx_q <= {tx_q[FRAME_W-2:0], 1'b0};

      if (shift_in)
        rx_q <= rx_next;

      // Final miso bit is taken on the same edge that publishes the byte.
      if (rd_load)
        rd_data <= rx_next;

      if (cnt_load)
        cnt_q <= cnt_init;
      else if (cnt_dec)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator sequencing FSM; serialises {cmd, wr_data} and, for read-data,
// collects the returned byte after a fixed turnaround.
//
//   state      | meaning
//   IDLE       | ss_n high, waiting for start
//   SELECT     | ss_n low, slave checks command, mosi shows frame MSB
//   SHIFT_OUT  | FRAME_W bits driven on mosi
//   TURNAROUND | RD_WAIT cycles of slave read latency
//   SHIFT_IN   | RD_W bits sampled from miso
//   FINISH     | ss_n high, done (and rd_valid for read-data) pulse
module spi_master_ctrl
  import spi_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      cmd,
  input  logic [7:0]      wr_data,
  output logic            busy,
  output logic            done,
  output logic            rd_valid,
  output logic [RD_W-1:0] rd_data,
  output logic            ss_n,
  output logic            mosi,
  input  logic            miso
);

  state_t           state, state_n;
  logic             rd_q;
  logic             accept;
  logic             sh_load, shift_out, shift_in, rd_load;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_init;
  logic             ss_n_d, busy_d, done_d, rd_valid_d;

  assign accept = (state == IDLE) && start;

  always_comb begin
    state_n   = state;
    sh_load   = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;
    rd_load   = 1'b0;
    cnt_load  = 1'b0;
    cnt_init  = '0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SELECT;
          sh_load = 1'b1;
        end
      end
      SELECT: begin
        state_n  = SHIFT_OUT;
        cnt_load = 1'b1;
        cnt_init = CNT_W'(FRAME_W - 1);
      end
      SHIFT_OUT: begin
        shift_out = 1'b1;
        if (cnt_zero) begin
          if (rd_q) begin
            state_n  = TURNAROUND;
            cnt_load = 1'b1;
            cnt_init = CNT_W'(RD_WAIT - 1);
          end else begin
            state_n = FINISH;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      TURNAROUND: begin
        if (cnt_zero) begin
          state_n  = SHIFT_IN;
          cnt_load = 1'b1;
          cnt_init = CNT_W'(RD_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SHIFT_IN: begin
        shift_in = 1'b1;
        if (cnt_zero) begin
          state_n = FINISH;
          rd_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    ss_n_d     = !(state_n inside {SELECT, SHIFT_OUT, TURNAROUND, SHIFT_IN});
    busy_d     = !ss_n_d;
    done_d     = (state_n == FINISH);
    rd_valid_d = (state_n == FINISH) && rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_q     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      ss_n     <= ss_n_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_valid <= rd_valid_d;
      if (accept)
        rd_q <= (cmd == CMD_RD_DATA);
    end
  end

  spi_master_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .frame     ({cmd, wr_data}),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .rd_load   (rd_load),
    .cnt_load  (cnt_load),
    .cnt_init  (cnt_init),
    .cnt_dec   (cnt_dec),
    .miso      (miso),
    .mosi      (mosi),
    .cnt_zero  (cnt_zero),
    .rd_data   (rd_data)
  );

endmodule
